// File: rtl/xenoa_boundary_map_q.sv
// ---------------------------------------------------------------------------
// xenoa_boundary_map_q
//   Binds time-qualified semantic events to XENOS boundaries. Each accepted
//   event is scaled by a boundary-type factor (saturating), compared against
//   its SLA threshold, has its severity escalated on breach, and is stamped
//   with a sequence number into a 256-bit audit record. Results are queued
//   in a DEPTH-entry output FIFO.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     input handshake; in_ready depends only on the
//                           registered FIFO occupancy
//   boundary_id .. causal_chain_id   event fields
//   out_valid / out_ready   output handshake on the FIFO head
//   boundary_key .. audit_record     FIFO head fields
//   cnt_clr                 synchronous clear of statistics and sequence
//   accept_count, breach_count       saturating statistics
// ---------------------------------------------------------------------------
module xenoa_boundary_map_q #(
    parameter int VAL_W    = 32,
    parameter int DEPTH    = 4,
    parameter int SEV_BUMP = 2,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [15:0]        boundary_id,
    input  logic [7:0]         boundary_type,
    input  logic [31:0]        contract_id,
    input  logic [31:0]        sla_id,
    input  logic [VAL_W-1:0]   sla_threshold,
    input  logic [31:0]        time_qualified_key,
    input  logic [VAL_W-1:0]   normalized_value,
    input  logic [3:0]         severity,
    input  logic [127:0]       causal_chain_id,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        boundary_key,
    output logic [VAL_W-1:0]   contract_bound_value,
    output logic [3:0]         boundary_severity,
    output logic               out_breach,
    output logic               out_sat,
    output logic [255:0]       audit_record,
    input  logic               cnt_clr,
    output logic [CNT_W-1:0]   accept_count,
    output logic [CNT_W-1:0]   breach_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = VAL_W + 4;  // largest factor (10) fits in 4 extra bits

    typedef struct packed {
        logic [31:0]      key;
        logic [VAL_W-1:0] val;
        logic [3:0]       sev;
        logic             breach;
        logic             sat;
        logic [255:0]     audit;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic [31:0]      seq_q;
    logic [CNT_W-1:0] acc_cnt_q, br_cnt_q;

    logic push, pop;

    // ---------------- event evaluation ----------------
    logic [3:0]       factor;
    logic [PW-1:0]    prod;
    logic             sat;
    logic [VAL_W-1:0] scaled;
    logic             breach;
    logic [4:0]       sev_sum;
    logic [3:0]       sev_out;
    logic [31:0]      key;
    entry_t           entry_d;

    always_comb begin
        factor = 4'd1;
        case (boundary_type)
            8'd1:    factor = 4'd2;
            8'd2:    factor = 4'd5;
            8'd3:    factor = 4'd10;
            default: factor = 4'd1;
        endcase
    end

    assign prod    = PW'(normalized_value) * PW'(factor);
    assign sat     = |prod[PW-1:VAL_W];
    assign scaled  = sat ? '1 : prod[VAL_W-1:0];
    assign breach  = scaled > sla_threshold;
    assign sev_sum = {1'b0, severity} + 5'(SEV_BUMP);
    assign sev_out = !breach ? severity : (sev_sum > 5'd15) ? 4'hF : sev_sum[3:0];
    assign key     = {boundary_id, time_qualified_key[15:0]};

    always_comb begin
        entry_d        = '0;
        entry_d.key    = key;
        entry_d.val    = scaled;
        entry_d.sev    = sev_out;
        entry_d.breach = breach;
        entry_d.sat    = sat;
        entry_d.audit  = {boundary_id, boundary_type, contract_id, sla_id,
                          causal_chain_id[63:0], key, sev_out, breach, sat,
                          6'b0, seq_q, 28'b0};
    end

    // Upper halves of the chain id and temporal key are not part of the record.
    logic unused_bits;
    assign unused_bits = ^{causal_chain_id[127:64], time_qualified_key[31:16]};

    // ---------------- FIFO control ----------------
    assign in_ready  = count_q < (AW+1)'(DEPTH);
    assign out_valid = count_q != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            seq_q     <= '0;
            acc_cnt_q <= '0;
            br_cnt_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= entry_d;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;

            // Clear wins over same-cycle accept: the entry keeps the old seq,
            // but neither the seq nor the counters advance for it.
            if (cnt_clr) begin
                seq_q     <= '0;
                acc_cnt_q <= '0;
                br_cnt_q  <= '0;
            end else if (push) begin
                seq_q <= seq_q + 1'b1;
                if (acc_cnt_q != '1) acc_cnt_q <= acc_cnt_q + 1'b1;
                if (breach && br_cnt_q != '1) br_cnt_q <= br_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- head outputs ----------------
    entry_t head;
    assign head                 = mem_q[rd_ptr_q];
    assign boundary_key         = head.key;
    assign contract_bound_value = head.val;
    assign boundary_severity    = head.sev;
    assign out_breach           = head.breach;
    assign out_sat              = head.sat;
    assign audit_record         = head.audit;
    assign accept_count         = acc_cnt_q;
    assign breach_count         = br_cnt_q;

endmodule

// File: tb/tb_xenoa_boundary_map_q.sv
module tb_xenoa_boundary_map_q;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, cnt_clr;
    logic [15:0]  boundary_id;
    logic [7:0]   boundary_type;
    logic [31:0]  contract_id, sla_id, sla_threshold, tqk, normalized_value;
    logic [3:0]   severity;
    logic [127:0] causal_chain_id;
    logic [31:0]  boundary_key, contract_bound_value;
    logic [3:0]   boundary_severity;
    logic         out_breach, out_sat;
    logic [255:0] audit_record;
    logic [15:0]  accept_count, breach_count;

    xenoa_boundary_map_q #(.VAL_W(32), .DEPTH(DEPTH), .SEV_BUMP(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .boundary_id(boundary_id), .boundary_type(boundary_type),
        .contract_id(contract_id), .sla_id(sla_id),
        .sla_threshold(sla_threshold), .time_qualified_key(tqk),
        .normalized_value(normalized_value), .severity(severity),
        .causal_chain_id(causal_chain_id),
        .out_valid(out_valid), .out_ready(out_ready),
        .boundary_key(boundary_key), .contract_bound_value(contract_bound_value),
        .boundary_severity(boundary_severity), .out_breach(out_breach),
        .out_sat(out_sat), .audit_record(audit_record),
        .cnt_clr(cnt_clr), .accept_count(accept_count), .breach_count(breach_count)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0]  key;
        logic [31:0]  val;
        logic [3:0]   sev;
        logic         br;
        logic         sat;
        logic [255:0] audit;
    } exp_t;

    exp_t        q[$];
    logic [31:0] m_seq;
    logic [15:0] m_acc, m_br;

    function automatic exp_t mk(input logic [31:0] sq);
        exp_t e;
        longint unsigned f, p;
        int s;
        case (boundary_type)
            8'd1: f = 2;
            8'd2: f = 5;
            8'd3: f = 10;
            default: f = 1;
        endcase
        p = longint'(normalized_value) * f;
        e.sat = p > 64'hFFFF_FFFF;
        e.val = e.sat ? 32'hFFFF_FFFF : p[31:0];
        e.br  = e.val > sla_threshold;
        s = int'(severity) + (e.br ? 2 : 0);
        e.sev = (s > 15) ? 4'hF : s[3:0];
        e.key = {boundary_id, tqk[15:0]};
        e.audit = {boundary_id, boundary_type, contract_id, sla_id, causal_chain_id[63:0],
                   e.key, e.sev, e.br, e.sat, 6'b0, sq, 28'b0};
        return e;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_seq <= '0;
            m_acc <= '0;
            m_br  <= '0;
        end else begin
            bit   acc, pp;
            exp_t e;
            acc = in_valid && (q.size() < DEPTH);
            pp  = (q.size() > 0) && out_ready;
            e   = mk(m_seq);
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(e);
            if (cnt_clr) begin
                m_seq <= '0;
                m_acc <= '0;
                m_br  <= '0;
            end else if (acc) begin
                m_seq <= m_seq + 1;
                if (m_acc != 16'hFFFF) m_acc <= m_acc + 1;
                if (e.br && m_br != 16'hFFFF) m_br <= m_br + 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("in_ready", in_ready, q.size() < DEPTH);
            chk("out_valid", out_valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("key", boundary_key, q[0].key);
                chk("value", contract_bound_value, q[0].val);
                chk("severity", boundary_severity, q[0].sev);
                chk("breach", out_breach, q[0].br);
                chk("sat", out_sat, q[0].sat);
                chk("audit", audit_record, q[0].audit);
            end
            chk("accept_count", accept_count, m_acc);
            chk("breach_count", breach_count, m_br);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ev(input logic [15:0] bid, input logic [7:0] typ, input logic [31:0] v,
                          input logic [31:0] thr, input logic [3:0] sv);
        boundary_id      = bid;
        boundary_type    = typ;
        normalized_value = v;
        sla_threshold    = thr;
        severity         = sv;
        contract_id      = {16'hC0DE, bid};
        sla_id           = {16'h5A1A, bid};
        tqk              = {16'hFFFF, bid ^ 16'h1234};
        causal_chain_id  = {64'h0123_4567_89AB_CDEF, 48'hFEED_FACE_0000, bid};
    endtask

    // Single event into an empty FIFO, head checked against literals, then popped.
    task automatic one(input logic [15:0] bid, input logic [7:0] typ, input logic [31:0] v,
                       input logic [31:0] thr, input logic [3:0] sv,
                       input logic [31:0] ev, input logic eb, input logic es,
                       input logic [3:0] esev, input logic [31:0] eseq);
        logic [31:0] ek;
        ek = {bid, bid ^ 16'h1234};
        out_ready = 1'b0;
        set_ev(bid, typ, v, thr, sv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lit_out_valid", out_valid, 1'b1);
        chk("lit_value", contract_bound_value, ev);
        chk("lit_breach", out_breach, eb);
        chk("lit_sat", out_sat, es);
        chk("lit_severity", boundary_severity, esev);
        chk("lit_key", boundary_key, ek);
        chk("lit_seq", audit_record[59:28], eseq);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cnt_clr = 1'b0;
        set_ev(16'h0, 8'h0, 32'h0, 32'h0, 4'h0);
        #3;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_audit", audit_record, 256'h0);
        chk("rst_value", contract_bound_value, 32'h0);
        chk("rst_accept", accept_count, 16'h0);
        #10 rst_n = 1'b1;
        tick();

        // scaling, saturation, threshold equality, severity clamp
        one(16'hA001, 8'd1, 32'd100,        32'd150, 4'd3,  32'd200,        1'b1, 1'b0, 4'd5,  32'd0);
        one(16'hA002, 8'd3, 32'hFFFF_FFF0,  32'd0,   4'd1,  32'hFFFF_FFFF,  1'b1, 1'b1, 4'd3,  32'd1);
        one(16'hA003, 8'd7, 32'd42,         32'd42,  4'd6,  32'd42,         1'b0, 1'b0, 4'd6,  32'd2);
        one(16'hA004, 8'd2, 32'd10,         32'd49,  4'd14, 32'd50,         1'b1, 1'b0, 4'd15, 32'd3);
        one(16'hA005, 8'd0, 32'd7,          32'd7,   4'd15, 32'd7,          1'b0, 1'b0, 4'd15, 32'd4);
        chk("lit_breach_count", breach_count, 16'd3);

        // fill with consumer stalled: 6 offered, 4 taken, head stable
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("lit_clr_accept", accept_count, 16'd0);
        for (int i = 0; i < 6; i++) begin
            set_ev(16'hB000 + 16'(i), 8'd1, 32'd1000 + 32'(i), 32'd5000, 4'd2);
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("lit_full_in_ready", in_ready, 1'b0);
        chk("lit_full_accept", accept_count, 16'd4);
        tick();
        tick();
        chk("lit_head_stable", contract_bound_value, 32'd2000);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("lit_drain_seq", audit_record[59:28], 32'(i));
            chk("lit_drain_val", contract_bound_value, 32'd2000 + 32'(2 * i));
            tick();
        end
        chk("lit_drained", out_valid, 1'b0);

        // streaming push/pop each cycle
        for (int i = 0; i < 10; i++) begin
            set_ev(16'hC000 + 16'(i), 8'(i % 4), 32'(3 * i + 1), 32'd20, 4'(i));
            in_valid = 1'b1;
            tick();
            chk("lit_stream_ready", in_ready, 1'b1);
        end
        in_valid = 1'b0;
        chk("lit_stream_accept", accept_count, 16'd14);
        tick();
        tick();

        // clear coinciding with an accept
        out_ready = 1'b0;
        set_ev(16'hD000, 8'd0, 32'd5, 32'd1, 4'd0);
        in_valid = 1'b1;
        cnt_clr = 1'b1;
        tick();
        in_valid = 1'b0;
        cnt_clr = 1'b0;
        chk("lit_clr_seq", audit_record[59:28], 32'd14);
        chk("lit_clr_acc", accept_count, 16'd0);
        chk("lit_clr_br", breach_count, 16'd0);

        // async reset in the middle of a burst
        for (int i = 0; i < 2; i++) begin
            set_ev(16'hE000 + 16'(i), 8'd2, 32'd9, 32'd100, 4'd1);
            in_valid = 1'b1;
            tick();
        end
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        chk("mid_rst_value", contract_bound_value, 32'h0);
        chk("mid_rst_audit", audit_record, 256'h0);
        chk("mid_rst_accept", accept_count, 16'h0);
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_out_valid", out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/xenoa_boundary_map_q.md
Name: xenoa_boundary_map_q

Overview:
Second-generation XENOA boundary semantics stage. It binds time-qualified semantic events to XENOS boundaries and scales values by boundary type with saturation. It checks each scaled value against a per-event SLA threshold, escalates severity on breach, stamps a sequence number into a 256-bit audit record, and buffers results in an output FIFO. Valid/ready handshakes on both sides; sits between the temporal semantics layer and the audit/contract engine.

Parameters:
VAL_W, 32, width of normalized_value, threshold and scaled value (8..32)
DEPTH, 4, output FIFO entries (power of 2, >=2)
SEV_BUMP, 2, severity increment applied on SLA breach
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  event valid
in_ready  out  1  event accepted when in_valid&&in_ready
boundary_id  in  16  XENOS boundary identifier
boundary_type  in  8  0=RACK 1=CLUSTER 2=DOMAIN 3=TENANT
contract_id  in  32  contract identifier
sla_id  in  32  SLA identifier
sla_threshold  in  VAL_W  breach threshold for this event
time_qualified_key  in  32  temporal key
normalized_value  in  VAL_W  normalized value
severity  in  4  input severity
causal_chain_id  in  128  causal chain id
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer ready
boundary_key  out  32  head key
contract_bound_value  out  VAL_W  head scaled value
boundary_severity  out  4  head severity
out_breach  out  1  head breached SLA
out_sat  out  1  head scaling saturated
audit_record  out  256  head audit record
cnt_clr  in  1  synchronous clear of counters and sequence number
accept_count  out  CNT_W  events accepted
breach_count  out  CNT_W  breaches accepted

Behaviour:
- Reset: all FIFO pointers, count, seq, counters = 0; out_valid=0; in_ready=1; all head data outputs 0.
- in_ready = (fifo count < DEPTH), from registered count only; no combinational path from out_ready.
- Acceptance at edge N: compute and write entry; out_valid=1 after edge N if FIFO was empty (latency 1 cycle).
- Key: {boundary_id, time_qualified_key[15:0]}.
- Scale factor: type 0 ->1, 1 ->2, 2 ->5, 3 ->10, other ->1. Product in VAL_W+4 bits; if > 2^VAL_W-1, value = all ones, sat=1.
- Breach = scaled (post-saturation) value > sla_threshold (strict, unsigned). Equal is not a breach.
- Severity: breach ? min(severity+SEV_BUMP, 15) : severity.
- Audit record, MSB first: boundary_id[16], boundary_type[8], contract_id[32], sla_id[32], causal_chain_id[63:0], key[32], out severity[4], breach[1], sat[1], 6'b0, seq[32], 28'b0.
- seq: 32-bit, value stamped = number of prior accepted events since reset/clear; wraps at 2^32.
- FIFO: push on accept, pop on out_valid&&out_ready; simultaneous push/pop keeps count; push refused when full even if popping that cycle. Head outputs reflect FIFO[rd_ptr]; stable while out_valid&&!out_ready.
- Counters: accept_count +1 per accept, breach_count +1 per breached accept; both saturate at all ones.
- cnt_clr: counters and seq -> 0 next edge; accept in same cycle is stamped with pre-clear seq, not counted. FIFO unaffected.
- Async reset mid-operation: FIFO flushed, all outputs to reset values immediately.

Test Plan:
- Reset, then type=1, value=100, thr=150, sev=3 -> 1 cycle later out_valid=1, value=200, breach=1, severity=5, key={id,tqk[15:0]}, seq field=0.
- Type=3, value=0xFFFF_FFF0 -> value=0xFFFF_FFFF, sat=1; type=7 value=42 -> value=42, sat=0; value equal to thr -> breach=0.
- sev=14, breach -> severity=15 (clamped).
- Hold out_ready=0, send 6 events -> 4 accepted, in_ready=0 after 4th, head stable; release -> drained in order, seq 0..3.
- Streaming push/pop each cycle with out_ready=1 -> throughput 1/cycle, count constant; accept_count tracks.
- cnt_clr asserted with accept -> entry seq = old value, counters read 0 next cycle; reset mid-burst -> out_valid=0, in_ready=1.
